// File: rtl/mdu_iterative.sv
// mdu_iterative: radix-2 iterative RV32M multiply/divide unit (N-cycle shift-add / restoring divide).
// Define MDU_ZERO_SKIP_EN to short-circuit zero-operand cases past the iteration loop.
module mdu_iterative #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic           neg_q, neg_d;
    logic [N-1:0]   b_q, b_d, result_q, result_d;
    logic [2*N-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sa, sb, b_zero, ovf, zskip, sp_hit, ge;
    logic [N-1:0]   a_mag, b_mag, sp_val, diff, lo, hi, res_fix;
    logic [N:0]     sum, sh;
    logic [2*N-1:0] mul_next, div_next, mres;
    assign sa     = ((op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110)) && A[N-1];
    assign sb     = ((op == 3'b001) || (op == 3'b100) || (op == 3'b110)) && B[N-1];
    assign a_mag  = sa ? -A : A;
    assign b_mag  = sb ? -B : B;
    assign b_zero = (B == {N{1'b0}});
    assign ovf    = op[2] && !op[0] && (A == {1'b1, {(N-1){1'b0}}}) && (&B);
`ifdef MDU_ZERO_SKIP_EN
    assign zskip  = op[2] ? ((A == {N{1'b0}}) && !b_zero) : ((A == {N{1'b0}}) || b_zero);
`else
    assign zskip  = 1'b0;
`endif
    assign sp_hit = (op[2] && (b_zero || ovf)) || zskip;
    // Quotient/remainder fallbacks for divide-by-zero and signed overflow.
    assign sp_val = zskip ? {N{1'b0}} : (op[1] ? (b_zero ? A : {N{1'b0}}) : (b_zero ? {N{1'b1}} : A));
    assign sum      = {1'b0, prod_q[2*N-1:N]} + {1'b0, prod_q[0] ? b_q : {N{1'b0}}};
    assign mul_next = {sum, prod_q[N-1:1]};
    assign sh       = {prod_q[2*N-1:N], prod_q[N-1]};
    assign ge       = sh >= {1'b0, b_q};
    assign diff     = sh[N-1:0] - b_q;
    assign div_next = {ge ? diff : sh[N-1:0], prod_q[N-2:0], ge};
    assign lo       = prod_q[N-1:0];
    assign hi       = prod_q[2*N-1:N];
    assign mres     = neg_q ? -prod_q : prod_q;
    assign res_fix  = op_q[2] ? (op_q[1] ? (neg_q ? -hi : hi) : (neg_q ? -lo : lo))
                              : ((op_q[1:0] == 2'b00) ? mres[N-1:0] : mres[2*N-1:N]);
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        b_d      = b_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_d    = op;
                    b_d     = b_mag;
                    neg_d   = sp_hit ? 1'b0 : ((op[2] && op[1]) ? sa : sa ^ sb);
                    cnt_d   = CW'(N - 1);
                    prod_d  = !sp_hit ? {{N{1'b0}}, a_mag} : (op[1] ? {sp_val, {N{1'b0}}} : {{N{1'b0}}, sp_val});
                    state_d = sp_hit ? FIX : CALC;
                end
                CALC: begin
                    prod_d  = op_q[2] ? div_next : mul_next;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == {CW{1'b0}}) ? FIX : CALC;
                end
                FIX: begin
                    result_d = res_fix;
                    state_d  = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 3'b000;
            neg_q    <= 1'b0;
            b_q      <= {N{1'b0}};
            prod_q   <= {(2*N){1'b0}};
            cnt_q    <= {CW{1'b0}};
            result_q <= {N{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed plus randomized checks of mdu_iterative against an arithmetic reference model.
module tb_mdu_iterative;
    localparam int N = 32;
    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [N-1:0] A = '0, B = '0;
    logic         busy, done;
    logic [N-1:0] result;
    int           checks = 0, failures = 0;
    logic [N-1:0] last_res = '0;

    mdu_iterative #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .abort(abort), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [63:0] ss, su, uu;
        int ia, ib;
        ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        su = {{32{a[31]}}, a} * {32'b0, b};
        uu = {32'b0, a} * {32'b0, b};
        ia = a;
        ib = b;
        case (o)
            3'd0: return uu[31:0];
            3'd1: return ss[63:32];
            3'd2: return su[63:32];
            3'd3: return uu[63:32];
            3'd4: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return N'(ia / ib);
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
                return N'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int busy_len(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        bit special;
        special = o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MDU_ZERO_SKIP_EN
        special = special || (o[2] ? (a == 0 && b != 0) : (a == 0 || b == 0));
`endif
        return special ? 2 : N + 2;
    endfunction

    task automatic run(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit poke, input string tag);
        int busy_n, done_n, done_at, exp_len;
        logic [N-1:0] exp;
        exp = model(o, a, b);
        exp_len = busy_len(o, a, b);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom);
        busy_n = 0; done_n = 0; done_at = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_n++;
            if (done) begin
                done_n++;
                done_at = busy_n;
            end
            start = poke && (busy_n == 5 || done);
        end
        start = 1'b0;
        check({tag, "_result"}, result, exp);
        check({tag, "_busy_cycles"}, N'(busy_n), N'(exp_len));
        check({tag, "_done_cycle"}, N'(done_at), N'(exp_len));
        check({tag, "_done_pulses"}, N'(done_n), N'(1));
        last_res = exp;
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        #2;
        check("reset_busy", N'(busy), N'(0));
        check("reset_done", N'(done), N'(0));
        check("reset_result", result, '0);
        @(negedge clk);
        rst = 1'b0;

        run(3'd0, 32'd7, -32'sd3, 1'b0, "mul_7_m3");
        run(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulh_min");
        run(3'd3, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulhu_min");
        run(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, "mulhsu_m1_2");
        run(3'd4, -32'sd7, 32'd2, 1'b0, "div_m7_2");
        run(3'd6, -32'sd7, 32'd2, 1'b0, "rem_m7_2");
        run(3'd5, 32'd100, 32'd7, 1'b1, "divu_100_7");
        run(3'd7, 32'd100, 32'd7, 1'b0, "remu_100_7");
        run(3'd4, 32'd5, 32'd0, 1'b0, "div_by0");
        run(3'd7, 32'd5, 32'd0, 1'b1, "remu_by0");
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
        run(3'd0, 32'd0, 32'd9, 1'b0, "mul_zero");
        run(3'd5, 32'd0, 32'd9, 1'b0, "divu_zero");

        @(negedge clk);
        op = 3'd4; A = -32'sd7; B = 32'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", N'(busy), N'(0));
        check("abort_done", N'(done), N'(0));
        check("abort_result", result, last_res);
        repeat (3) @(negedge clk);
        check("abort_idle", N'(busy | done), N'(0));
        run(3'd0, 32'd3, 32'd4, 1'b0, "mul_after_abort");

        @(negedge clk);
        op = 3'd0; A = 32'd9; B = 32'd9; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", N'(busy), N'(0));

        @(negedge clk);
        op = 3'd0; A = 32'd11; B = 32'd13; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_busy", N'(busy), N'(0));
        check("rst_mid_done", N'(done), N'(0));
        check("rst_mid_result", result, '0);
        #1 rst = 1'b0;
        last_res = '0;

        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: ra = '0;
                1: rb = '0;
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                4: rb = N'($urandom_range(1, 15));
                default: ;
            endcase
            run(3'($urandom), ra, rb, 1'($urandom), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative multiply/divide unit for the RV32M instructions (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits in the execute stage beside the N-bit ALU and takes the same rs1/rs2 operands.
- Its result goes to the writeback mux in place of the ALU result.
- While it works it holds the core stalled (PC and register-file write enable gated by busy & ~done).

Parameters:
- N, 32, operand and result width; iteration count equals N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A  input  N  rs1 operand.
- B  input  N  rs2 operand.
- abort  input  1  synchronous kill; returns the unit to IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  N  operation result; holds its value until the next accepted start.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers=0. Applies immediately, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1:
  - Latch op.
  - Latch operand magnitudes. Signed treatment: A for MULH/MULHSU/DIV/REM; B for MULH/DIV/REM. All other operands are unsigned.
  - Record the result sign.
  - Load counter=N-1 and go to CALC.
- Special cases, detected in IDLE; these skip CALC and go straight to FIX:
  - DIV/DIVU with B=0: quotient=all ones.
  - REM/REMU with B=0: remainder=A.
  - DIV with A=-2^(N-1) and B=-1: quotient=-2^(N-1).
  - REM with A=-2^(N-1) and B=-1: remainder=0.
- CALC, multiply: radix-2 shift-add on a 2N-bit product register, one bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC exit: counter decrements each cycle; at counter=0 go to FIX. CALC lasts exactly N cycles.
- FIX:
  - Apply the sign: two's-complement negate when the recorded sign is negative.
  - Remainder sign follows the dividend.
  - Select the result: MUL takes the low N bits; MULH/MULHSU/MULHU take the high N bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register result, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still 1 in this cycle.
- Latency, with start sampled at edge k:
  - Normal operation: done high in the cycle after edge k+N+1 (N+2 busy cycles).
  - Special case: done high in the cycle after edge k+1 (2 busy cycles).
- A and B are don't-care after the start edge, since operands are captured.
- start while busy=1 is ignored. start in the DONE cycle is ignored; the core must re-issue it.
- abort=1 in any state: go to IDLE next edge, done not asserted, result unchanged.
- abort and start high together in IDLE: abort wins, no operation is accepted.
- All arithmetic is modulo 2^N per RV32M. There are no exceptions and no flags.

Optional Feature:
- Macro MDU_ZERO_SKIP_EN.
- Defined:
  - Any multiply with A=0 or B=0 takes the special-case path (IDLE->FIX, result 0, 2 busy cycles).
  - DIV/DIVU/REM/REMU with A=0 and B!=0 also take that path (result 0, 2 busy cycles).
- Undefined: these operand cases run the full N-cycle CALC. Results are identical either way; only latency differs.

Test Plan:
- N=32, MUL A=7, B=-3 -> result=0xFFFFFFEB; done exactly 34 cycles after the start edge; busy high for 34 cycles.
- MULH A=0x80000000, B=0x80000000 -> 0x40000000. MULHU on the same operands -> 0x40000000. MULHSU A=-1, B=2 -> 0xFFFFFFFF.
- DIV A=-7, B=2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU A=100, B=7 -> 14. REMU on the same operands -> 2.
- Special cases:
  - DIV A=5, B=0 -> 0xFFFFFFFF.
  - REMU A=5, B=0 -> 5.
  - DIV A=0x80000000, B=-1 -> 0x80000000.
  - REM A=0x80000000, B=-1 -> 0.
  - Each has done 2 cycles after start.
- Start a DIV, assert abort at CALC cycle 10 -> IDLE next cycle; done never pulses; result keeps its prior value. A following MUL 3*4 -> 12.
- Assert rst mid-CALC -> busy=0, done=0, result=0 immediately, without waiting for a clock edge. start pulsed while busy=1 -> no effect on the running operation or its result.
